sync_copy_fork_n: RTL and testbench

SYNC_COPY_FORK_N -- requirements
Module: sync_copy_fork_n

---
 rtl/sync_copy_fork_n.sv | 54 +++++
 tb/tb_sync_copy_fork_n.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_copy_fork_n.sv
// sync_copy_fork_n: one-token register forked to N_OUT independently completing branches.
// Optional stall counter port o_stall_cnt when COPYFORK_STALLCNT_EN is defined.
module sync_copy_fork_n #(
  parameter int WIDTH = 32,
  parameter int N_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_drive,
  output logic                   o_free,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [N_OUT-1:0]       i_mask,
  output logic [N_OUT-1:0]       o_driveNext,
  input  logic [N_OUT-1:0]       i_freeNext,
  output logic [N_OUT*WIDTH-1:0] o_data
`ifdef COPYFORK_STALLCNT_EN
  ,
  output logic [15:0]            o_stall_cnt
`endif
);
  logic [WIDTH-1:0] r_data;
  logic [N_OUT-1:0] r_pend;
  logic [N_OUT-1:0] w_left;
  logic [N_OUT-1:0] w_pend_nx;
  logic [WIDTH-1:0] w_data_nx;
  logic             w_xfer;
  // Branches still owed a copy after this cycle; free once none remain.
  always_comb begin
    w_left    = r_pend & ~i_freeNext;
    o_free    = ~|w_left;
    w_xfer    = i_drive & o_free;
    w_pend_nx = w_xfer ? i_mask : w_left;
    w_data_nx = w_xfer ? i_data : r_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_data <= '0;
    end else begin
      r_pend <= w_pend_nx;
      r_data <= w_data_nx;
    end
  end
  assign o_driveNext = r_pend;
  assign o_data      = {N_OUT{r_data}};
`ifdef COPYFORK_STALLCNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if (i_drive && !o_free && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_sync_copy_fork_n.sv
// tb_sync_copy_fork_n: directed plus random checks of sync_copy_fork_n against a per-branch token model.
module tb_sync_copy_fork_n;
  localparam int W = 32;
  localparam int N = 4;
  logic           clk = 0;
  logic           rst = 1;
  logic           i_drive = 0;
  logic           o_free;
  logic [W-1:0]   i_data = '0;
  logic [N-1:0]   i_mask = '0;
  logic [N-1:0]   o_driveNext;
  logic [N-1:0]   i_freeNext = '0;
  logic [N*W-1:0] o_data;
`ifdef COPYFORK_STALLCNT_EN
  logic [15:0]    o_stall_cnt;
`endif
  int vectors = 0;
  int miscompares = 0;
  bit       m_owed [N];
  logic [W-1:0] m_word = '0;
  int       m_stall = 0;

  sync_copy_fork_n #(.WIDTH(W), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .o_free(o_free), .i_data(i_data), .i_mask(i_mask),
    .o_driveNext(o_driveNext), .i_freeNext(i_freeNext), .o_data(o_data)
`ifdef COPYFORK_STALLCNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_free();
    for (int k = 0; k < N; k++) if (m_owed[k] && !i_freeNext[k]) return 0;
    return 1;
  endfunction

  task automatic step(input bit d, input logic [W-1:0] dat, input logic [N-1:0] m, input logic [N-1:0] f);
    logic [N-1:0] ev;
    bit ef;
    i_drive = d; i_data = dat; i_mask = m; i_freeNext = f;
    #2;
    ef = model_free();
    for (int k = 0; k < N; k++) ev[k] = m_owed[k];
    chk("free", o_free, ef);
    chk("driveNext", o_driveNext, ev);
    chk("data", o_data, {N{m_word}});
`ifdef COPYFORK_STALLCNT_EN
    chk("stall_cnt", o_stall_cnt, m_stall);
`endif
    if (d && !ef && m_stall < 65535) m_stall++;
    if (d && ef) begin
      m_word = dat;
      for (int k = 0; k < N; k++) m_owed[k] = m[k];
    end else
      for (int k = 0; k < N; k++) if (f[k]) m_owed[k] = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; i_drive = 1; i_data = $urandom; i_mask = '1; i_freeNext = '1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < N; k++) m_owed[k] = 0;
    m_word = '0; m_stall = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    step(0, 0, 0, 0);
    // One token per cycle with both branches ready
    step(1, 32'h1, 4'b0011, 4'b1111);
    step(1, 32'h2, 4'b0011, 4'b1111);
    step(1, 32'h3, 4'b0011, 4'b1111);
    step(0, 0, 0, 4'b1111);
    step(0, 0, 0, 0);
    // Independent completion; upstream held off until the last branch completes
    step(1, 32'hDEADBEEF, 4'b0011, 4'b0000);
    step(1, 32'h11111111, 4'b0011, 4'b0001);
    step(1, 32'h22222222, 4'b0011, 4'b0001);
    step(1, 32'h33333333, 4'b0011, 4'b0001);
    step(0, 0, 0, 4'b0010);
    step(0, 0, 0, 0);
    // Sparse mask; unselected readies ignored
    step(1, 32'hA5, 4'b0101, 4'b1010);
    step(0, 0, 0, 4'b1010);
    step(0, 0, 0, 4'b1010);
    step(0, 0, 0, 4'b0101);
    step(0, 0, 0, 0);
    // Empty mask is swallowed
    step(1, 32'h55, 4'b0000, 4'b0000);
    step(1, 32'h66, 4'b0011, 4'b0000);
    step(0, 0, 0, 4'b0011);
    step(0, 0, 0, 0);
    // Mid-flight reset drops the token
    step(1, 32'h77, 4'b0011, 4'b0000);
    step(0, 0, 0, 4'b0000);
    do_reset();
    step(0, 0, 0, 4'b0011);
    step(1, 32'h88, 4'b0011, 4'b0000);
    step(0, 0, 0, 4'b0011);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom, $urandom, $urandom);
`ifdef COPYFORK_STALLCNT_EN
    step(1, 32'h99, 4'b0011, 4'b0000);
    for (int i = 0; i < 70000; i++) step(1, $urandom, 4'b0011, 4'b0001);
    chk("stall_sat", o_stall_cnt, 16'hFFFF);
    do_reset();
    #2;
    chk("stall_rst", o_stall_cnt, 16'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
